// File: rtl/ex_mem_latch_if.sv
// EX -> MEM pipeline bus: ALU result/status and instruction control in,
// registered MEM-stage fields out.
interface ex_mem_latch_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_W  = 3
);
    logic              ex_valid;
    logic [DATA_W-1:0] alu_out;
    logic              alu_ofl;
    logic              alu_z;
    logic              alu_cout;
    logic              alu_neg;
    logic [2:0]        ex_setop;
    logic              ex_ofl_chk;
    logic              ex_flag_we;
    logic              ex_wr_en;
    logic [REG_W-1:0]  ex_wr_reg;
    logic              ex_mem_rd;
    logic              ex_mem_wr;
    logic [DATA_W-1:0] ex_st_data;
    logic              stall;
    logic              flush;

    logic              mem_valid;
    logic [DATA_W-1:0] mem_result;
    logic              mem_wr_en;
    logic [REG_W-1:0]  mem_wr_reg;
    logic              mem_mem_rd;
    logic              mem_mem_wr;
    logic [DATA_W-1:0] mem_st_data;

    modport master (
        output ex_valid, alu_out, alu_ofl, alu_z, alu_cout, alu_neg,
               ex_setop, ex_ofl_chk, ex_flag_we, ex_wr_en, ex_wr_reg,
               ex_mem_rd, ex_mem_wr, ex_st_data, stall, flush,
        input  mem_valid, mem_result, mem_wr_en, mem_wr_reg,
               mem_mem_rd, mem_mem_wr, mem_st_data
    );

    modport slave (
        input  ex_valid, alu_out, alu_ofl, alu_z, alu_cout, alu_neg,
               ex_setop, ex_ofl_chk, ex_flag_we, ex_wr_en, ex_wr_reg,
               ex_mem_rd, ex_mem_wr, ex_st_data, stall, flush,
        output mem_valid, mem_result, mem_wr_en, mem_wr_reg,
               mem_mem_rd, mem_mem_wr, mem_st_data
    );
endinterface

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: resolves set-condition ops from ALU status,
// holds the {V,C,N,Z} flag register and a sticky overflow trap with counter.
module ex_mem_latch #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_W  = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    ex_mem_latch_if.slave    bus,
    input  logic             exc_clr,
    output logic [3:0]       flags,
    output logic             ofl_exc,
    output logic [CNT_W-1:0] ofl_cnt
);
    localparam logic [2:0] SETOP_SEQ = 3'd1;
    localparam logic [2:0] SETOP_SLT = 3'd2;
    localparam logic [2:0] SETOP_SLE = 3'd3;
    localparam logic [2:0] SETOP_SCO = 3'd4;

    logic              acc_c;
    logic              ovf_c;
    logic              lt_c;
    logic [DATA_W-1:0] set_res_c;

    assign acc_c = bus.ex_valid & ~bus.stall & ~bus.flush;
    assign ovf_c = acc_c & bus.ex_ofl_chk & bus.alu_ofl;
    assign lt_c  = bus.alu_neg ^ bus.alu_ofl;

    // Set-condition ops assume the ALU computed A-B with signed status.
    always_comb begin
        set_res_c = bus.alu_out;
        case (bus.ex_setop)
            SETOP_SEQ: set_res_c = DATA_W'(bus.alu_z);
            SETOP_SLT: set_res_c = DATA_W'(lt_c);
            SETOP_SLE: set_res_c = DATA_W'(bus.alu_z | lt_c);
            SETOP_SCO: set_res_c = DATA_W'(bus.alu_cout);
            default:   set_res_c = bus.alu_out;
        endcase
    end

    // Pipeline fields: flush squashes enables only, stall holds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_valid   <= 1'b0;
            bus.mem_result  <= '0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_wr_reg  <= '0;
            bus.mem_mem_rd  <= 1'b0;
            bus.mem_mem_wr  <= 1'b0;
            bus.mem_st_data <= '0;
        end else if (bus.flush) begin
            bus.mem_valid   <= 1'b0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_mem_rd  <= 1'b0;
            bus.mem_mem_wr  <= 1'b0;
        end else if (!bus.stall) begin
            bus.mem_valid   <= bus.ex_valid;
            bus.mem_result  <= set_res_c;
            bus.mem_wr_en   <= bus.ex_valid & bus.ex_wr_en & ~ovf_c;
            bus.mem_wr_reg  <= bus.ex_wr_reg;
            bus.mem_mem_rd  <= bus.ex_valid & bus.ex_mem_rd & ~ovf_c;
            bus.mem_mem_wr  <= bus.ex_valid & bus.ex_mem_wr & ~ovf_c;
            bus.mem_st_data <= bus.ex_st_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else if (acc_c && bus.ex_flag_we) begin
            flags <= {bus.alu_ofl, bus.alu_cout, bus.alu_neg, bus.alu_z};
        end
    end

    // A same-cycle overflow beats exc_clr and restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ofl_exc <= 1'b0;
            ofl_cnt <= '0;
        end else if (ovf_c) begin
            ofl_exc <= 1'b1;
            if (exc_clr) begin
                ofl_cnt <= CNT_W'(1);
            end else if (ofl_cnt != {CNT_W{1'b1}}) begin
                ofl_cnt <= ofl_cnt + CNT_W'(1);
            end
        end else if (exc_clr) begin
            ofl_exc <= 1'b0;
            ofl_cnt <= '0;
        end
    end
endmodule

// File: doc/ex_mem_latch.md
Name: ex_mem_latch

Overview:
- EX/MEM pipeline register directly downstream of the 16-bit execute ALU.
- Consumes the ALU result and status outputs (result, overflow, zero, carry-out, negative).
- Resolves set-condition instructions (SEQ/SLT/SLE/SCO) from the ALU status and registers the result plus control for the memory stage.
- Keeps an architectural flag register and a sticky overflow exception with a saturating event counter.

Parameters:
- DATA_W, 16, datapath width; must match the ALU.
- REG_W, 3, register-specifier width.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX stage holds a real instruction this cycle.
- alu_out  in  DATA_W  ALU result.
- alu_ofl  in  1  ALU overflow, already masked to add ops by the ALU.
- alu_z  in  1  ALU zero.
- alu_cout  in  1  ALU adder carry-out.
- alu_neg  in  1  ALU negative; valid only when the ALU sign input was 1.
- ex_setop  in  3  0=NONE, 1=SEQ, 2=SLT, 3=SLE, 4=SCO; 5-7 are reserved and treated as NONE.
- ex_ofl_chk  in  1  instruction traps on signed overflow.
- ex_flag_we  in  1  instruction updates the flag register.
- ex_wr_en  in  1  register-file write enable.
- ex_wr_reg  in  REG_W  destination register.
- ex_mem_rd  in  1  load.
- ex_mem_wr  in  1  store.
- ex_st_data  in  DATA_W  store data.
- stall  in  1  hold the EX/MEM register.
- flush  in  1  squash the instruction entering MEM.
- exc_clr  in  1  clear the sticky exception and the counter.
- mem_valid  out  1  registered valid.
- mem_result  out  DATA_W  registered result.
- mem_wr_en  out  1  registered write enable.
- mem_wr_reg  out  REG_W  registered destination register.
- mem_mem_rd  out  1  registered load.
- mem_mem_wr  out  1  registered store.
- mem_st_data  out  DATA_W  registered store data.
- flags  out  4  flag register {V,C,N,Z}.
- ofl_exc  out  1  sticky overflow exception.
- ofl_cnt  out  CNT_W  saturating overflow count.

Behaviour:
- Reset (rst_n=0, asynchronous): every output and register goes to 0 immediately; on release, state holds until the first accepted edge.
- Accept condition: acc = ex_valid & ~stall & ~flush.
- Set-condition results assume the ALU computed A-B with sign=1. All are zero-extended to DATA_W.
  - SEQ: result = alu_z.
  - SLT: result = alu_neg ^ alu_ofl.
  - SLE: result = alu_z | (alu_neg ^ alu_ofl).
  - SCO: result = alu_cout.
  - NONE or reserved: result = alu_out.
- Latency: one cycle. EX inputs at edge k appear on the mem_* outputs after edge k.
- Priority per edge: flush > stall > normal.
  - flush=1: mem_valid, mem_wr_en, mem_mem_rd and mem_mem_wr go to 0. mem_result, mem_wr_reg and mem_st_data keep their old values. Flags and exception state do not update.
  - stall=1 and flush=0: every register holds, including flags, ofl_exc and ofl_cnt.
  - Normal, ex_valid=0: load a bubble (mem_valid and all enables 0); data fields take the inputs.
  - Normal, ex_valid=1: load all fields.
- Flag register: updates only when acc & ex_flag_we. New value is {alu_ofl, alu_cout, alu_neg, alu_z}.
- Overflow event: ovf = acc & ex_ofl_chk & alu_ofl.
  - On ovf: ofl_exc <= 1 and ofl_cnt <= ofl_cnt+1, saturating at all-ones with no wrap.
  - The offending instruction still enters MEM, but with mem_wr_en, mem_mem_rd and mem_mem_wr forced to 0 (no architectural write); mem_valid stays 1.
- exc_clr=1: ofl_exc <= 0 and ofl_cnt <= 0.
  - If ovf occurs in the same cycle, ofl_exc <= 1 and ofl_cnt <= 1 (set wins; the count restarts).
  - exc_clr is honoured even while stall=1.
- Non-accepted instructions never change flags, ofl_exc or ofl_cnt.
- mem_mem_rd and mem_mem_wr both high is passed through unchanged; this block does not check for it.

Test Plan:
- Reset mid-stream: run 3 valid instructions, then pulse rst_n low between edges -> all outputs 0 asynchronously, before the next edge.
- Set-conditions, ALU at A=0x7FFF, B=0x8000 giving alu_out=0xFFFF, alu_ofl=1, alu_neg=1, alu_z=0:
  - SLT -> mem_result=0x0000.
  - SEQ with alu_z=1 -> 0x0001.
  - SLE with alu_z=1, alu_neg=0, alu_ofl=0 -> 0x0001.
  - SCO with alu_cout=1 -> 0x0001.
- Stall then flush: load alu_out=0x1234 with wr_en=1, stall for 2 cycles -> outputs hold 0x1234. Then flush=1 together with stall=1 -> mem_valid=0, mem_wr_en=0, mem_result still 0x1234.
- Overflow trap: ex_ofl_chk=1, alu_ofl=1, wr_en=1, mem_wr=1 -> mem_valid=1, mem_wr_en=0, mem_mem_wr=0, ofl_exc=1, ofl_cnt=1. A second identical instruction during stall -> ofl_cnt stays 1.
- Counter saturation with CNT_W=2: 5 accepted overflows -> ofl_cnt=3. Then exc_clr together with a 6th overflow -> ofl_exc=1, ofl_cnt=1. Then exc_clr alone -> ofl_exc=0, ofl_cnt=0.
- Flags: ex_flag_we=1 with alu_z=1, alu_cout=1 -> flags=0b0101. Same inputs with ex_flag_we=0 or ex_valid=0 -> flags unchanged.
